// File: rtl/types_pkg.sv
// Shared types for the pipeline sequencer.
//   ctrl_state_t : sequencer states (RUN, FLUSH, DRAIN, HALTED)
//   fwd_sel_t    : forwarding mux source (regfile, EX/MEM, MEM/WB)
//   HAZ_*        : bit positions inside the decode hazard vector
//   fwd_pick     : turns an (s2, s3) hazard pair into a select, s2 first
package types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_S2 = 2'd1,
    FWD_S3 = 2'd2
  } fwd_sel_t;

  localparam int HAZ_W      = 11;
  localparam int HAZ_A_S3   = 0;
  localparam int HAZ_A_S2   = 1;
  localparam int HAZ_B_S2   = 2;
  localparam int HAZ_B_S3   = 3;
  localparam int HAZ_BR_S2  = 4;
  localparam int HAZ_BR_S3  = 5;
  localparam int HAZ_R0_S2  = 6;
  localparam int HAZ_R0_S3  = 7;
  localparam int HAZ_SW_S2  = 8;
  localparam int HAZ_SW_S3  = 9;
  localparam int HAZ_SW_S2B = 10;

  // The EX/MEM producer is younger than the MEM/WB one, so it wins.
  function automatic fwd_sel_t fwd_pick(input logic s2, input logic s3);
    if (s2)      return FWD_S2;
    else if (s3) return FWD_S3;
    else         return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear, wins over inc
//   count      : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer between decode hazard logic and the pipeline registers.
//   clk, rst_n            : clock, asynchronous active-low reset
//   haz[10:0], stall      : decode hazard vector and load-use stall request
//   branch_taken          : branch resolved taken in EX
//   halt_id               : HALT instruction sitting in ID
//   cnt_clr               : synchronous clear of both performance counters
//   pc_we, ifid_we        : PC / IF-ID write enables (same cycle)
//   idex_bubble           : load NOP into ID/EX (same cycle)
//   ifid_flush            : squash IF/ID (same cycle)
//   fwd_*_sel             : registered forward selects aligned with ID/EX
//   halted                : pipeline drained and frozen
//   stall_cnt, flush_cnt  : saturating event counters
//   ctrl_state            : current sequencer state, for debug and checkers
module pipeline_ctrl
  import types_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HAZ_W-1:0]  haz,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              halt_id,
  input  logic              cnt_clr,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        fwd_br_sel,
  output logic [1:0]        fwd_r0_sel,
  output logic [1:0]        fwd_sw_sel,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output ctrl_state_t       ctrl_state
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  ctrl_state_t   state, next_state;
  logic [DW-1:0] drain_cnt;
  logic          drain_load, drain_dec;
  logic          stall_inc, flush_inc;
  fwd_sel_t      a_nxt, b_nxt, br_nxt, r0_nxt, sw_nxt;

  assign ctrl_state = state;
  assign halted     = (state == HALTED);

  // Next state and same-cycle pipeline controls.
  always_comb begin
    next_state  = state;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    drain_load  = 1'b0;
    drain_dec   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          next_state  = FLUSH;
        end else if (stall) begin
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (halt_id) begin
          // HALT itself moves into ID/EX; fetch freezes from now on.
          drain_load = 1'b1;
          next_state = DRAIN;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      FLUSH: begin
        if (branch_taken) begin
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          next_state  = FLUSH;
        end else begin
          // ID holds the squashed slot: hazards, stall and halt are moot.
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          idex_bubble = 1'b1;
          next_state  = RUN;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          // The HALT was fetched down the wrong path; redirect instead.
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          next_state  = FLUSH;
        end else begin
          idex_bubble = 1'b1;
          if (drain_cnt == '0) next_state = HALTED;
          else                 drain_dec  = 1'b1;
        end
      end
      HALTED: begin
        idex_bubble = 1'b1;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Decoded selects for whatever is in ID right now.
  always_comb begin
    a_nxt  = fwd_pick(haz[HAZ_A_S2], haz[HAZ_A_S3]);
    b_nxt  = fwd_pick(haz[HAZ_B_S2], haz[HAZ_B_S3]);
    br_nxt = fwd_pick(haz[HAZ_BR_S2], haz[HAZ_BR_S3]);
    r0_nxt = fwd_pick(haz[HAZ_R0_S2], haz[HAZ_R0_S3]);
    sw_nxt = fwd_pick(haz[HAZ_SW_S2] | haz[HAZ_SW_S2B], haz[HAZ_SW_S3]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      drain_cnt  <= '0;
      fwd_a_sel  <= FWD_RF;
      fwd_b_sel  <= FWD_RF;
      fwd_br_sel <= FWD_RF;
      fwd_r0_sel <= FWD_RF;
      fwd_sw_sel <= FWD_RF;
    end else begin
      state <= next_state;
      if (drain_load)     drain_cnt <= DW'(DRAIN_CYC - 1);
      else if (drain_dec) drain_cnt <= drain_cnt - DW'(1);
      // A bubble in ID/EX must not forward anything.
      if (idex_bubble) begin
        fwd_a_sel  <= FWD_RF;
        fwd_b_sel  <= FWD_RF;
        fwd_br_sel <= FWD_RF;
        fwd_r0_sel <= FWD_RF;
        fwd_sw_sel <= FWD_RF;
      end else begin
        fwd_a_sel  <= a_nxt;
        fwd_b_sel  <= b_nxt;
        fwd_br_sel <= br_nxt;
        fwd_r0_sel <= r0_nxt;
        fwd_sw_sel <= sw_nxt;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule
